// File: rtl/serial_tx.sv
// serial_tx: UART transmitter, 8N1, LSB first.
// Bytes enter a small circular FIFO through a valid/ready handshake and are
// sent back to back with no idle gap between queued frames.
module serial_tx #(
    parameter int OSCRATE  = 12_000_000,
    parameter int BAUDRATE = 9600,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int BAUDDIV = OSCRATE / BAUDRATE;
    localparam int PW      = $clog2(DEPTH);
    // BAUDDIV >= 2, so CW >= 1 and BAUDDIV-1 always fits.
    localparam int CW      = $clog2(BAUDDIV);

    localparam logic [CW-1:0] BAUD_LOAD = CW'(BAUDDIV - 1);
    localparam logic [PW:0]   FULL      = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic [7:0]      mem_q [DEPTH];

    logic            wr_en;
    logic            pop;
    logic            fifo_nonempty;
    logic            baud_done;

    assign ready         = (count_q != FULL);
    assign wr_en         = valid && ready && !rst;
    assign fifo_nonempty = (count_q != '0);
    assign baud_done     = (baud_q == '0);
    assign tx            = tx_q;
    assign busy          = busy_q;

    // FIFO storage: no reset so it maps onto RAM; the shift register acts as
    // the registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    // Frame sequencing: next state, baud counter, bit index, shift register, pop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = BAUD_LOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = BAUD_LOAD;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q - CW'(1);
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = BAUD_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - CW'(1);
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    if (fifo_nonempty) begin
                        // Next frame starts straight after the stop bit.
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        baud_d  = BAUD_LOAD;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointers/count, line level and busy flag derived from next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (count_d != '0) || (state_d != S_IDLE);
    end

    // State register with synchronous reset; reset aborts any frame and
    // discards queued bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one instance at BAUDDIV=16, one at a
// truncated divider (100/7 -> 14).
module tb_serial_tx;

    logic       clk;
    logic       rst;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic       tx_a, tx_b;
    logic       busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    serial_tx #(.OSCRATE(16), .BAUDRATE(1), .DEPTH(4)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .data  (data_a),
        .valid (valid_a),
        .ready (ready_a),
        .tx    (tx_a),
        .busy  (busy_a)
    );

    serial_tx #(.OSCRATE(100), .BAUDRATE(7), .DEPTH(4)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .data  (data_b),
        .valid (valid_b),
        .ready (ready_b),
        .tx    (tx_b),
        .busy  (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic tx_sel(input bit sel);
        return sel ? tx_b : tx_a;
    endfunction

    function automatic logic busy_sel(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    // Called right after the edge that began the start bit (or pre clocks
    // into it). Checks the first and last clock of every bit, so each bit
    // must last exactly bd clocks.
    task automatic expect_frame(input bit sel, input logic [7:0] b, input int bd,
                                input int pre, input bit last);
        logic [9:0] bits;
        int len;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            len = (i == 0) ? bd - pre : bd;
            check($sformatf("byte%02h bit%0d first", b, i), 32'(tx_sel(sel)), 32'(bits[i]));
            repeat (len - 1) tick();
            check($sformatf("byte%02h bit%0d last", b, i), 32'(tx_sel(sel)), 32'(bits[i]));
            if (i == 9) begin
                check($sformatf("byte%02h busy in stop", b), 32'(busy_sel(sel)), 32'd1);
            end
            tick();
        end
        if (last) begin
            check($sformatf("byte%02h busy after", b), 32'(busy_sel(sel)), 32'd0);
            check($sformatf("byte%02h tx idle after", b), 32'(tx_sel(sel)), 32'd1);
        end else begin
            check($sformatf("byte%02h busy chained", b), 32'(busy_sel(sel)), 32'd1);
        end
        $display("frame 0x%02h on dut %0d checked", b, sel);
    endtask

    initial begin
        rst     = 1'b1;
        data_a  = 8'h00;
        data_b  = 8'h00;
        valid_a = 1'b0;
        valid_b = 1'b0;

        // Reset with random traffic on the inputs.
        repeat (2) begin
            valid_a = 1'($urandom_range(0, 1));
            data_a  = 8'($urandom);
            valid_b = 1'($urandom_range(0, 1));
            data_b  = 8'($urandom);
            tick();
        end
        check("reset tx", 32'(tx_a), 32'd1);
        check("reset ready", 32'(ready_a), 32'd1);
        check("reset busy", 32'(busy_a), 32'd0);
        check("reset tx b", 32'(tx_b), 32'd1);
        valid_a = 1'b0;
        valid_b = 1'b0;
        rst     = 1'b0;
        repeat (20) tick();
        check("post-reset tx idle", 32'(tx_a), 32'd1);
        check("post-reset busy", 32'(busy_a), 32'd0);
        $display("reset sequence done");

        // Single byte: busy one edge after accept, start bit one edge later.
        data_a  = 8'h55;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        check("single busy after accept", 32'(busy_a), 32'd1);
        check("single tx before start", 32'(tx_a), 32'd1);
        check("single ready after accept", 32'(ready_a), 32'd1);
        tick();
        expect_frame(1'b0, 8'h55, 16, 0, 1'b1);

        // Back-to-back writes on consecutive clocks.
        data_a  = 8'hA5;
        valid_a = 1'b1;
        tick();
        data_a  = 8'h3C;
        tick();
        valid_a = 1'b0;
        expect_frame(1'b0, 8'hA5, 16, 0, 1'b0);
        expect_frame(1'b0, 8'h3C, 16, 0, 1'b1);

        // Fill: 7 consecutive writes, only 5 fit (4 queued + 1 in shift reg).
        for (int c = 0; c < 7; c++) begin
            data_a  = 8'((c + 1) * 8'h11);
            valid_a = 1'b1;
            check($sformatf("full ready cycle%0d", c), 32'(ready_a), (c < 5) ? 32'd1 : 32'd0);
            tick();
        end
        valid_a = 1'b0;
        // Start bit began after the second write edge; five clocks elapsed.
        expect_frame(1'b0, 8'h11, 16, 5, 1'b0);
        expect_frame(1'b0, 8'h22, 16, 0, 1'b0);
        expect_frame(1'b0, 8'h33, 16, 0, 1'b0);
        expect_frame(1'b0, 8'h44, 16, 0, 1'b0);
        expect_frame(1'b0, 8'h55, 16, 0, 1'b1);
        repeat (40) tick();
        check("full no extra frame tx", 32'(tx_a), 32'd1);
        check("full no extra frame busy", 32'(busy_a), 32'd0);
        check("full ready restored", 32'(ready_a), 32'd1);

        // Mid-frame reset during data bit 3 of 0x5A with 0xC3 queued.
        data_a  = 8'h5A;
        valid_a = 1'b1;
        tick();
        data_a  = 8'hC3;
        tick();
        valid_a = 1'b0;
        repeat (4 * 16 + 3) tick();
        check("midreset in data bit3", 32'(tx_a), 32'd1);
        check("midreset busy before", 32'(busy_a), 32'd1);
        rst     = 1'b1;
        data_a  = 8'hEE;
        valid_a = 1'b1;
        tick();
        check("midreset tx", 32'(tx_a), 32'd1);
        check("midreset busy", 32'(busy_a), 32'd0);
        check("midreset ready", 32'(ready_a), 32'd1);
        rst     = 1'b0;
        valid_a = 1'b0;
        repeat (48) tick();
        check("midreset no frame tx", 32'(tx_a), 32'd1);
        check("midreset no frame busy", 32'(busy_a), 32'd0);
        $display("mid-frame reset done");
        data_a  = 8'h96;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        check("post-reset write busy", 32'(busy_a), 32'd1);
        tick();
        expect_frame(1'b0, 8'h96, 16, 0, 1'b1);

        // Truncated divider: 100/7 = 14 clocks per bit.
        data_b  = 8'h55;
        valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        check("trunc busy after accept", 32'(busy_b), 32'd1);
        tick();
        expect_frame(1'b1, 8'h55, 14, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
